output_streamer: RTL

- Sits at the output end of the dense-layer network.
- Captures the parallel result vector when the network pulses outputs_ready, then drains it one word per transfer over a valid/ready stream to downstream logic (host link, UART framer).
- Buffers exactly one result vector and flags any result pulse it had to drop.

---
 rtl/output_streamer.sv | 98 +++++++++
 1 files changed

// File: rtl/output_streamer.sv
// Captures one parallel result vector on outputs_ready and drains it word by word
// over a valid/ready stream; sticky overrun flags result pulses that could not be buffered.
module output_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 2,
  parameter int INDEX_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         outputs_ready,
  input  logic signed [DATA_WIDTH-1:0] outputs [NUM_OUTPUTS],
  output logic signed [DATA_WIDTH-1:0] stream_data,
  output logic [INDEX_WIDTH-1:0]       stream_index,
  output logic                         stream_valid,
  output logic                         stream_last,
  input  logic                         stream_ready,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         clear_overrun
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_OUTPUTS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                         r_state;
  logic signed [DATA_WIDTH-1:0]   r_buf [NUM_OUTPUTS];
  logic signed [DATA_WIDTH-1:0]   r_data;
  logic [INDEX_WIDTH-1:0]         r_idx;
  logic                           r_valid;
  logic                           r_last;
  logic                           r_busy;
  logic                           r_overrun;

  logic                           w_xfer;
  logic                           w_final;
  logic                           w_accept;
  logic                           w_drop;
  logic [INDEX_WIDTH-1:0]         w_next_idx;

  // A pulse coinciding with the final transfer is taken, so the stream restarts with no bubble.
  assign w_xfer     = (r_state == S_STREAM) && stream_ready;
  assign w_final    = w_xfer && (r_idx == LAST_IDX);
  assign w_accept   = outputs_ready && ((r_state == S_IDLE) || w_final);
  assign w_drop     = outputs_ready && !w_accept;
  assign w_next_idx = r_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (reset && w_accept) begin
      r_buf <= outputs;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_accept) begin
        r_state <= S_STREAM;
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_data  <= outputs[0];
        r_last  <= (LAST_IDX == '0);
      end else if (w_final) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_last  <= 1'b0;
        r_idx   <= '0;
      end else if (w_xfer) begin
        r_idx  <= w_next_idx;
        r_data <= r_buf[w_next_idx];
        r_last <= (w_next_idx == LAST_IDX);
      end
    end
  end

  assign stream_data  = r_data;
  assign stream_index = r_idx;
  assign stream_valid = r_valid;
  assign stream_last  = r_last;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
